seq_detector_prog: RTL

- Programmable serial bit-pattern detector. Generalises the fixed 0101 Moore detector.
- Pattern and length are runtime-loadable up to MAX_LEN bits; overlapping or non-overlapping detection is selectable; input is qualified by a valid strobe.
- A saturating match counter is included.
- Sits on serial data paths: framing/sync-word search, protocol preamble detect.

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_detector_prog_sat_counter.sv | 27 ++
 rtl/seq_detector_prog.sv | 89 ++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants for the programmable sequence detector.
//   DEF_PATTERN / DEF_LEN : pattern loaded at reset (0101, length 4), which
//                           lets the block stand in for the fixed 0101 detector.
//   OVL_ON / OVL_OFF      : values of overlap_en.
//   len_w()               : width needed to hold a length of 0..max_len.
package seq_det_pkg;

  localparam int   DEF_PATTERN = 'b0101;
  localparam int   DEF_LEN     = 4;
  localparam logic OVL_ON      = 1'b1;
  localparam logic OVL_OFF     = 1'b0;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_detector_prog_sat_counter.sv
// sat_counter: W-bit up counter that saturates at all-ones.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (count -> 0)
//   inc   : add one when not saturated
//   clr   : synchronous clear, has priority over inc
//   cnt   : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      r_cnt <= '0;
    else if (clr)                    r_cnt <= '0;
    else if (inc && (r_cnt != '1))   r_cnt <= r_cnt + 1'b1;
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: programmable serial bit-pattern detector.
//   clk, reset   : rising-edge clock, asynchronous active-low reset
//   pat_load     : latch pattern/pat_len and flush the history
//   pattern      : pattern[pat_len-1] is the first bit, pattern[0] the last
//   pat_len      : active length, 1..MAX_LEN; anything else disables detection
//   overlap_en   : 1 keeps history after a hit, 0 restarts the fill count
//   d, d_valid   : serial bit and its qualifier
//   clear_count  : synchronous clear of match_count
//   match        : registered one-cycle pulse after the completing bit
//   match_count  : saturating number of matches
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pat_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap_en,
  input  logic               d,
  input  logic               d_valid,
  input  logic               clear_count,
  output logic               match,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_match;

  logic [MAX_LEN-1:0] w_hist_nxt;
  logic [LEN_W-1:0]   w_fill_nxt;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_len_ok;
  logic               w_hit;

  assign w_hist_nxt = {r_hist[MAX_LEN-2:0], d};
  assign w_fill_nxt = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;

  // Ones in the low r_len bits; a shift by MAX_LEN leaves all ones.
  assign w_mask   = ~({MAX_LEN{1'b1}} << r_len);
  assign w_len_ok = (r_len != '0) && (r_len <= FILL_MAX);

  // Load wins over a simultaneous data bit, so it also suppresses the hit.
  assign w_hit = d_valid && !pat_load && w_len_ok && (w_fill_nxt >= r_len) &&
                 (((w_hist_nxt ^ r_pat) & w_mask) == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pat   <= MAX_LEN'(DEF_PATTERN);
      r_len   <= LEN_W'(DEF_LEN);
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else if (pat_load) begin
      r_pat   <= pattern;
      r_len   <= pat_len;
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else if (d_valid) begin
      r_hist  <= w_hist_nxt;
      // Non-overlapping mode forces a full fresh pattern after each hit.
      r_fill  <= (w_hit && (overlap_en == OVL_OFF)) ? '0 : w_fill_nxt;
      r_match <= w_hit;
    end else begin
      r_match <= 1'b0;
    end
  end

  assign match = r_match;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_hit),
    .clr   (clear_count),
    .cnt   (match_count)
  );

endmodule
